// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops bytes from a FIFO read port (data one cycle after rd_en)
// and packs PACK_BYTES of them into one output word, first byte in the low lane.
// The output is a single registered slot with valid/ready handshake.
// Optional build macro FIFO_PACK_TIMEOUT_EN: flush a partial word once the
// accumulator has sat idle for TIMEOUT cycles; without it partial words wait.

module fifo_word_packer #(
    parameter int FIFO_WIDTH = 8,
    parameter int PACK_BYTES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic                             empty,
    input  logic [FIFO_WIDTH-1:0]            data_out,
    output logic                             rd_en,
    output logic                             m_valid,
    output logic [FIFO_WIDTH*PACK_BYTES-1:0] m_data,
    output logic [PACK_BYTES-1:0]            m_keep,
    input  logic                             m_ready
);

    localparam int CW = $clog2(PACK_BYTES + 1);
    localparam int LW = $clog2(PACK_BYTES);
    localparam logic [CW:0] FULL = (CW + 1)'(PACK_BYTES);
    localparam logic [CW:0] LAST = (CW + 1)'(PACK_BYTES - 1);

    if (PACK_BYTES < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_word_packer: PACK_BYTES must be >= 2 and TIMEOUT >= 1");
    end

    logic [PACK_BYTES-1:0][FIFO_WIDTH-1:0] acc;
    logic [CW-1:0]                         cnt;
    logic                                  inflight;

    logic [CW:0]                           cnt_w;
    logic [CW:0]                           occupancy;
    logic                                  out_free;
    logic                                  full_now;
    logic                                  completes;
    logic                                  move_full;
    logic                                  flush;
    logic [LW-1:0]                         lane;
    logic [PACK_BYTES-1:0][FIFO_WIDTH-1:0] word;
    logic [PACK_BYTES-1:0]                 keep;

    assign cnt_w     = {1'b0, cnt};
    // bytes already held plus the one on its way from the FIFO
    assign occupancy = cnt_w + {{CW{1'b0}}, inflight};
    assign out_free  = !m_valid || m_ready;
    assign full_now  = (cnt_w == FULL);
    // the landing byte finishes the word: load it straight into the output
    // register so a full stream never leaves a bubble on rd_en
    assign completes = inflight && (cnt_w == LAST);
    assign move_full = out_free && (full_now || completes);
    assign lane      = LW'(cnt);

    // pop whenever the accumulator has room, counting a word leaving this cycle
    assign rd_en = rstN && !empty &&
                   ((occupancy < FULL) || ((occupancy == FULL) && move_full));

`ifdef FIFO_PACK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 1);

    logic [IW-1:0] idle_cnt;
    logic          idle;

    assign idle  = (cnt != '0) && !full_now && !inflight && !rd_en;
    // flush on the TIMEOUT-th consecutive idle cycle, once the output slot is free
    assign flush = idle && (idle_cnt == IDLE_LIMIT) && out_free;

    // idle cycle counter; any pop or non-idle cycle restarts it
    always_ff @(posedge clk) begin
        if (!rstN) begin
            idle_cnt <= '0;
        end else if (!idle || flush) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LIMIT) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign flush = 1'b0;
`endif

    // next output word: accumulator plus any completing byte, unused lanes zeroed
    always_comb begin
        word = acc;
        keep = '1;
        if (completes) begin
            word[PACK_BYTES-1] = data_out;
        end
        if (flush) begin
            for (int i = 0; i < PACK_BYTES; i++) begin
                keep[i] = (i < int'(cnt));
                if (i >= int'(cnt)) begin
                    word[i] = '0;
                end
            end
        end
    end

    // accumulator, inflight tracking and the output register
    always_ff @(posedge clk) begin
        if (!rstN) begin
            acc      <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_keep   <= '0;
        end else begin
            inflight <= rd_en;

            if (move_full || flush) begin
                m_valid <= 1'b1;
                m_data  <= word;
                m_keep  <= keep;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (move_full && full_now && inflight) begin
                // held word leaves while a new byte lands: it starts the next word
                acc[0] <= data_out;
                cnt    <= CW'(1);
            end else if (move_full || flush) begin
                cnt <= '0;
            end else if (inflight) begin
                acc[lane] <= data_out;
                cnt       <= cnt + 1'b1;
            end
        end
    end

endmodule
